// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage feeding a downstream SIPO receiver.
//
// Takes one WIDTH-bit word per valid/ready handshake and shifts it out one bit per clock.
// serial_valid qualifies each frame bit, and frame_done pulses on the last bit of the frame.
//
// Optional feature (compile-time macro PISO_PARITY_EN):
//   When defined, a parity bit follows each word, giving a frame of WIDTH+1 bits.
//   The parity bit is the XOR of the word, inverted when PARITY_ODD != 0.
//   When undefined, no parity state or logic is built and PARITY_ODD is ignored.
//
// Parameters:
//   WIDTH       data word width (2..32)
//   MSB_FIRST   1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//   PARITY_ODD  0: even parity; 1: odd parity (only with PISO_PARITY_EN)
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-low reset
//   in_valid      upstream word available
//   in_ready      block can accept a word this cycle (combinational)
//   in_data       word to serialize, sampled only on accept
//   serial_out    serial bit stream (registered)
//   serial_valid  serial_out carries a frame bit (registered)
//   busy          a frame is in flight (registered)
//   frame_done    pulse on the cycle the last frame bit is driven (registered)
module piso_serializer #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned MSB_FIRST  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic             frame_done
);

    localparam int unsigned     CntW    = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
    typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic              serial_out_q, serial_out_d;
    logic              serial_valid_q, serial_valid_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic              accept;

`ifdef PISO_PARITY_EN
    logic              parity_q, parity_d;
`else
    logic              unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    assign accept = in_valid & in_ready;

    // Ready when idle or on the final frame-bit cycle, so frames can run back to back.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            case (state_q)
                StIdle:  in_ready = 1'b1;
`ifdef PISO_PARITY_EN
                StShift: in_ready = 1'b0;
                StPar:   in_ready = 1'b1;
`else
                StShift: in_ready = (cnt_q == CntLast);
`endif
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Next state, counter and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    shift_d = in_data;
`ifdef PISO_PARITY_EN
                    parity_d = (^in_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            StShift: begin
                if (cnt_q != CntLast) begin
                    cnt_d = cnt_q + 1'b1;
                    // Keep the bit to send next at the output end of the register.
                    shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                               : {1'b0, shift_q[WIDTH-1:1]};
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = StPar;
                    cnt_d   = cnt_q + 1'b1;
`else
                    if (accept) begin
                        state_d = StShift;
                        cnt_d   = '0;
                        shift_d = in_data;
                    end else begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
`endif
                end
            end
`ifdef PISO_PARITY_EN
            StPar: begin
                if (accept) begin
                    state_d  = StShift;
                    cnt_d    = '0;
                    shift_d  = in_data;
                    parity_d = (^in_data) ^ (PARITY_ODD != 0);
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered: derive them from the state being entered.
    always_comb begin
        serial_valid_d = (state_d != StIdle);
        busy_d         = (state_d != StIdle);
        serial_out_d   = 1'b0;
        frame_done_d   = 1'b0;
        if (state_d == StShift) begin
            serial_out_d = (MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0];
`ifndef PISO_PARITY_EN
            frame_done_d = (cnt_d == CntLast);
`endif
        end
`ifdef PISO_PARITY_EN
        else if (state_d == StPar) begin
            serial_out_d = parity_d;
            frame_done_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= StIdle;
            cnt_q          <= '0;
            shift_q        <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            shift_q        <= shift_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
`ifdef PISO_PARITY_EN
            parity_q       <= parity_d;
`endif
        end
    end

    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: an MSB-first and an LSB-first instance share one stimulus stream.
// Each accepted word is expanded into its expected bit sequence, with due cycles, in a per-lane
// queue. A separate monitor pops and compares bits as the DUT drives them.
module tb_piso_serializer;

    localparam int unsigned W      = 4;
    localparam bit          PodTb  = 1'b0;
`ifdef PISO_PARITY_EN
    localparam int unsigned FL = W + 1;
`else
    localparam int unsigned FL = W;
`endif

    typedef struct {
        bit b;
        bit last;
        int due;
    } exp_t;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] in_data  = '0;
    logic [1:0]   rdy, so, sv, bz, fd;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc      = 0;
    int   last_due = 0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1), .PARITY_ODD(PodTb)) u_msb (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (rdy[0]),
        .in_data      (in_data),
        .serial_out   (so[0]),
        .serial_valid (sv[0]),
        .busy         (bz[0]),
        .frame_done   (fd[0])
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(0), .PARITY_ODD(PodTb)) u_lsb (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (rdy[1]),
        .in_data      (in_data),
        .serial_out   (so[1]),
        .serial_valid (sv[1]),
        .busy         (bz[1]),
        .frame_done   (fd[1])
    );

    function automatic void chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Frame bit i of word w: data bits in the chosen order, then the parity bit.
    function automatic bit ref_bit(input logic [W-1:0] w, input int i, input bit msb);
        if (i >= int'(W)) return (^w) ^ PodTb;
        return msb ? w[W-1-i] : w[i];
    endfunction

    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        for (int i = 0; i < int'(FL); i++) begin
            e.last = (i == int'(FL) - 1);
            e.due  = cyc + 1 + i;
            e.b    = ref_bit(w, i, 1'b1);
            q0.push_back(e);
            e.b    = ref_bit(w, i, 1'b0);
            q1.push_back(e);
        end
        last_due = cyc + int'(FL);
    endtask

    // Model readiness: nothing queued past this cycle.
    function automatic bit model_ready();
        return cyc >= last_due;
    endfunction

    task automatic check_ready();
        chk("in_ready_msb", rdy[0], model_ready());
        chk("in_ready_lsb", rdy[1], model_ready());
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] w);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int t = 0; t < 4 * int'(FL) && !done; t++) begin
            check_ready();
            if (model_ready()) begin
                push_word(w);
                done = 1'b1;
            end
            @(negedge clk);
        end
        if (!done) begin
            failures++;
            $display("FAIL send_timeout: got no accept expected accept of %b (cycle %0d)", w, cyc);
        end
        in_data = W'($urandom);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        for (int k = 0; k < n; k++) begin
            check_ready();
            @(negedge clk);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("%s_serial_out_l%0d", tag, l), so[l], 1'b0);
            chk($sformatf("%s_serial_valid_l%0d", tag, l), sv[l], 1'b0);
            chk($sformatf("%s_busy_l%0d", tag, l), bz[l], 1'b0);
            chk($sformatf("%s_frame_done_l%0d", tag, l), fd[l], 1'b0);
            chk($sformatf("%s_in_ready_l%0d", tag, l), rdy[l], 1'b0);
        end
    endtask

    // Asynchronous reset in the middle of a clock cycle; the frame in flight is dropped.
    task automatic reset_pulse();
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midrst");
        q0.delete();
        q1.delete();
        last_due = 0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic mon_lane(input int l);
        exp_t e;
        bit   have;
        have = 1'b0;
        e.b = 1'b0;
        e.last = 1'b0;
        e.due = 0;
        if (l == 0) begin
            if (q0.size() != 0 && q0[0].due == cyc) begin
                e = q0.pop_front();
                have = 1'b1;
            end
        end else begin
            if (q1.size() != 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                have = 1'b1;
            end
        end
        chk($sformatf("serial_valid_l%0d", l), sv[l], have);
        chk($sformatf("busy_l%0d", l), bz[l], have);
        chk($sformatf("serial_out_l%0d", l), so[l], have ? e.b : 1'b0);
        chk($sformatf("frame_done_l%0d", l), fd[l], have ? e.last : 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            mon_lane(0);
            mon_lane(1);
        end
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);

        // Directed cases
        idle(2);
        send(4'b1011);
        idle(6);
        send(4'b0001);
        idle(6);
        send(4'b1100);      // back to back with in_valid held high
        send(4'b0110);
        idle(8);
        send(4'b1010);      // stall: next word offered mid-frame
        idle(1);
        send(4'b0011);
        idle(6);
        send(4'b1111);      // reset lands on bit 2
        reset_pulse();
        send(4'b0101);
        idle(6);

        // Random traffic
        for (int it = 0; it < 200; it++) begin
            if ($urandom_range(0, 2) != 0) send(W'($urandom));
            else idle(int'($urandom_range(1, 3)));
        end

        in_valid = 1'b0;
        for (int t = 0; t < 4 * int'(FL) && (q0.size() != 0 || q1.size() != 0); t++) idle(1);
        chk("drain_empty", (q0.size() == 0 && q1.size() == 0), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
